// File: rtl/conv_window_3x3_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_3x3_gen_pkg
// Purpose  : Shared definitions for the streaming 3x3 window generator:
//            size/counter width, tap count and tap indices (row-major,
//            0 = top-left .. 8 = bottom-right), and the FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package conv_window_3x3_gen_pkg;

  localparam int SIZE_W    = 10;
  localparam int NUM_TAPS  = 9;
  localparam int RAM_DEPTH = 1 << SIZE_W;

  localparam logic [SIZE_W-1:0] SIZE_ONE = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] SIZE_TWO = SIZE_W'(2);

  // Tap indices inside the packed window
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_window_3x3_gen_line_delay_ram.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_3x3_gen_line_delay_ram
// Purpose  : Programmable-depth line delay built on a simple dual-port RAM
//            with 1-cycle synchronous read. Each write returns, W writes
//            later, the word written at the same slot.
// Ports    : clk      - clock
//            rst      - synchronous active-high reset
//            i_clr    - restart the circular pointer at slot 0
//            i_we     - write/advance (one pixel beat)
//            i_depth  - delay depth W (2..1023)
//            i_wdata  - word written this beat
//            o_rdata  - word written W beats before the current one
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_3x3_gen_line_delay_ram
  import conv_window_3x3_gen_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [SIZE_W-1:0] i_depth,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [RAM_DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [SIZE_W-1:0] r_ptr;
  logic [SIZE_W-1:0] w_ptr_inc;
  logic [SIZE_W-1:0] w_rd_addr;

  assign w_ptr_inc = (r_ptr == i_depth - SIZE_ONE) ? '0 : r_ptr + SIZE_ONE;

  // Read the slot the pointer will hold after this edge, so the registered
  // read data is already the oldest word when the next beat arrives, even
  // with back-to-back beats. The read slot never equals the write slot.
  assign w_rd_addr = i_clr ? '0 : (i_we ? w_ptr_inc : r_ptr);

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[r_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[w_rd_addr];
      if (i_clr) begin
        r_ptr <= '0;
      end else if (i_we) begin
        r_ptr <= w_ptr_inc;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/conv_window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_3x3_gen
// Purpose  : Streaming zero-padded 3x3 window generator. Accepts one pixel
//            word per beat in raster order, buffers two rows in line delays
//            and emits one window per input pixel (flush appended inside).
// Ports    : system_clk, rst (sync, active high)
//            start, row_size (W), col_size (H) - frame start / geometry
//            in_valid, in_data, in_ready       - pixel input handshake
//            out_valid, win_data, out_row, out_col, out_last - window out
//            busy, done                        - frame status
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_3x3_gen
  import conv_window_3x3_gen_pkg::*;
#(
  parameter int FEATURE_WIDTH = 8,
  parameter int DATA_W        = FEATURE_WIDTH * 2
) (
  input  logic                       system_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SIZE_W-1:0]          row_size,
  input  logic [SIZE_W-1:0]          col_size,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [NUM_TAPS*DATA_W-1:0] win_data,
  output logic [SIZE_W-1:0]          out_row,
  output logic [SIZE_W-1:0]          out_col,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  state_t            r_state, w_state_nxt;
  logic [SIZE_W-1:0] r_row_size, r_col_size;
  logic [SIZE_W-1:0] r_in_col, r_in_row;
  logic [SIZE_W-1:0] r_oc_col, r_oc_row;
  logic              r_flush_done;
  logic              r_out_valid, r_out_last;
  logic [SIZE_W-1:0] r_out_row, r_out_col;
  logic [DATA_W-1:0] r_win [NUM_TAPS];
  logic [DATA_W-1:0] w_ld1_q, w_ld2_q;

  logic w_start_ok, w_accept, w_flush_beat, w_beat, w_emit;
  logic w_in_col_last, w_frame_last, w_fill_end;
  logic w_oc_col_last, w_oc_last;
  logic [DATA_W-1:0] w_beat_data;
  logic [2:0] w_row_pad, w_col_pad;

  assign w_start_ok   = start && (r_state == ST_IDLE) &&
                        (row_size >= SIZE_TWO) && (col_size >= SIZE_TWO);
  assign w_accept     = in_valid && in_ready;
  assign w_flush_beat = (r_state == ST_FLUSH) && !r_flush_done;
  assign w_beat       = w_accept || w_flush_beat;
  assign w_beat_data  = w_flush_beat ? '0 : in_data;

  assign w_in_col_last = (r_in_col == r_row_size - SIZE_ONE);
  assign w_frame_last  = w_in_col_last && (r_in_row == r_col_size - SIZE_ONE);
  // Beat index W+1 is row 1, column 1: bottom-right tap of the first window
  assign w_fill_end    = (r_in_row == SIZE_ONE) && (r_in_col == SIZE_ONE);
  assign w_oc_col_last = (r_oc_col == r_row_size - SIZE_ONE);
  assign w_oc_last     = w_oc_col_last && (r_oc_row == r_col_size - SIZE_ONE);

  assign w_emit = w_beat && ((r_state == ST_RUN) || (r_state == ST_FLUSH) ||
                             ((r_state == ST_FILL) && w_fill_end));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_start_ok) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        // With W=2,H=2 the last pixel is also the fill-end beat
        if (w_accept && w_frame_last)    w_state_nxt = ST_FLUSH;
        else if (w_accept && w_fill_end) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (w_accept && w_frame_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Leave one cycle after the last flush beat so done follows out_last
        if (r_flush_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------- frame counters
  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_row_size   <= '0;
      r_col_size   <= '0;
      r_in_col     <= '0;
      r_in_row     <= '0;
      r_oc_col     <= '0;
      r_oc_row     <= '0;
      r_flush_done <= 1'b0;
    end else if (w_start_ok) begin
      r_row_size   <= row_size;
      r_col_size   <= col_size;
      r_in_col     <= '0;
      r_in_row     <= '0;
      r_oc_col     <= '0;
      r_oc_row     <= '0;
      r_flush_done <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_in_col_last) begin
          r_in_col <= '0;
          r_in_row <= r_in_row + SIZE_ONE;
        end else begin
          r_in_col <= r_in_col + SIZE_ONE;
        end
      end
      if (w_emit) begin
        if (w_oc_col_last) begin
          r_oc_col <= '0;
          r_oc_row <= r_oc_row + SIZE_ONE;
        end else begin
          r_oc_col <= r_oc_col + SIZE_ONE;
        end
        if (w_oc_last) r_flush_done <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------- line delays
  conv_window_3x3_gen_line_delay_ram #(.DATA_W(DATA_W)) u_line_delay_row1 (
    .clk     (system_clk),
    .rst     (rst),
    .i_clr   (w_start_ok),
    .i_we    (w_beat),
    .i_depth (r_row_size),
    .i_wdata (w_beat_data),
    .o_rdata (w_ld1_q)
  );

  conv_window_3x3_gen_line_delay_ram #(.DATA_W(DATA_W)) u_line_delay_row2 (
    .clk     (system_clk),
    .rst     (rst),
    .i_clr   (w_start_ok),
    .i_we    (w_beat),
    .i_depth (r_row_size),
    .i_wdata (w_ld1_q),
    .o_rdata (w_ld2_q)
  );

  // ------------------------------------------------------ window registers
  // Right column takes the newest pixel of each row (p[n-2W], p[n-W], p[n]).
  always_ff @(posedge system_clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) r_win[k] <= '0;
    end else if (w_beat) begin
      r_win[TAP_TL] <= r_win[TAP_TC];
      r_win[TAP_TC] <= r_win[TAP_TR];
      r_win[TAP_TR] <= w_ld2_q;
      r_win[TAP_ML] <= r_win[TAP_MC];
      r_win[TAP_MC] <= r_win[TAP_MR];
      r_win[TAP_MR] <= w_ld1_q;
      r_win[TAP_BL] <= r_win[TAP_BC];
      r_win[TAP_BC] <= r_win[TAP_BR];
      r_win[TAP_BR] <= w_beat_data;
    end
  end

  // ------------------------------------------------------ output counters
  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_out_valid <= w_emit;
      r_out_last  <= w_emit && w_oc_last;
      if (w_emit) begin
        r_out_row <= r_oc_row;
        r_out_col <= r_oc_col;
      end
    end
  end

  // Padding mask: edge rows/columns of the window are zeroed at image
  // borders, which also hides row wrap-around and stale line-delay data.
  assign w_row_pad = {(r_out_row == r_col_size - SIZE_ONE), 1'b0, (r_out_row == '0)};
  assign w_col_pad = {(r_out_col == r_row_size - SIZE_ONE), 1'b0, (r_out_col == '0)};

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam int ROW = k / 3;
    localparam int COL = k % 3;
    assign win_data[k*DATA_W +: DATA_W] =
      (w_row_pad[ROW] || w_col_pad[COL]) ? '0 : r_win[k];
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;

endmodule
`default_nettype wire
